alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high on a rising edge.
REQ-005 cmd_a, cmd_b  in  8 each  operands.
REQ-006 cmd_sel  in  4  ALU opcode (0000 add … 0011 div … 1111 equal).
REQ-007 cmd_tag  in  4  opaque ID, returned with the response.
REQ-008 alu_a, alu_b, alu_sel  out  8/8/4  registered drive to the downstream combinational ALU.
REQ-009 alu_result, alu_quotient, alu_remainder, alu_carry, alu_dbz  in  16/8/8/1/1  ALU outputs.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_result, rsp_remainder, rsp_tag  out  16/8/4  captured result, remainder, tag.
REQ-012 rsp_flags  out  3  [0] carry, [1] divide-by-zero, [2] zero.
REQ-013 dbz_count  out  8  saturating count of divide-by-zero responses.
REQ-014 busy  out  1  high when the FIFO is non-empty or the state is not IDLE.

Function
REQ-015 Commands SHALL be written to a FIFO_DEPTH-entry FIFO; cmd_ready = not full, from registered occupancy only (no same-cycle pop passthrough).
REQ-016 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-017 IDLE, FIFO non-empty: pop head, register into alu_a/alu_b/alu_sel and the internal tag, go to ISSUE; IDLE, FIFO empty: stay.
REQ-018 ISSUE: unconditionally capture alu_result, alu_remainder and flags into rsp_* registers, assert rsp_valid, go to RESP.
REQ-019 RESP: hold all rsp_* stable while rsp_ready is low.
REQ-020 RESP with rsp_ready high: deassert rsp_valid; if the FIFO is non-empty, pop and load the ALU registers and go to ISSUE; otherwise go to IDLE.
REQ-021 Latency: a command accepted at edge N into an empty FIFO in IDLE SHALL raise rsp_valid after edge N+2; peak throughput is one response per 2 cycles.
REQ-022 Flag rules:
  - flags[0] = alu_carry AND (alu_sel == 0000), so carry appears only for add.
  - flags[1] = alu_dbz.
  - flags[2] = (alu_result == 0).
REQ-023 dbz_count SHALL increment by 1 on each completed response handshake with flags[1] set, and saturate at 255.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 Responses SHALL emerge in acceptance order with their original tag.
REQ-026 alu_a/alu_b/alu_sel SHALL hold their last value outside ISSUE.

Reset
REQ-027 On rst_n low, immediately and regardless of clk:
  - state = IDLE, FIFO emptied.
  - rsp_valid = 0, rsp_result = 0, rsp_remainder = 0, rsp_flags = 0, rsp_tag = 0.
  - alu_a = 0, alu_b = 0, alu_sel = 0, dbz_count = 0.
  - cmd_ready = 1 once reset is released.
REQ-028 A reset during ISSUE or RESP SHALL discard the in-flight and queued commands with no response.

Structure
REQ-029 The package alu_ctrl_pkg SHALL hold:
  - the state enum;
  - the opcode constants (ALU_ADD=0000, ALU_SUB=0001, ALU_MUL=0010, ALU_DIV=0011, … ALU_EQ=1111);
  - the flag bit indices.
REQ-030 The FIFO SHALL be the sub-module alu_cmd_fifo, with parameters for width (24 bits: a, b, sel, tag) and depth.
REQ-031 The ALU SHALL stay external; alu_ctrl instantiates no arithmetic.

Verification
REQ-032 Add: a=200, b=100, sel=0000, tag=3 -> rsp_result=0x012C, flags=001, tag=3, rsp_valid 2 cycles after accept.
REQ-033 Divide: a=100, b=7, sel=0011 -> rsp_result=0x000E, rsp_remainder=2, flags=000; then b=0 -> rsp_result=0xDEAD, flags[1]=1, dbz_count=1.
REQ-034 Backpressure: rsp_ready=0, push tags 0..5 -> tags 0..4 accepted, cmd_ready low at tag 5; release rsp_ready -> tags 0..5 returned in order, each stable while stalled.
REQ-035 Zero/compare: a=5, b=5, sel=1010 -> result 0, flags=100; sel=1111 -> result 1, flags=000.
REQ-036 Reset: assert rst_n low while in RESP with 2 queued -> all outputs at reset values asynchronously, busy=0, no stale response after release.
REQ-037 Saturation: 260 divide-by-zero responses -> dbz_count=255.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller: FSM states,
// opcode encodings, response flag bit positions and the queued command layout.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_MUL  = 4'h2;
    localparam logic [3:0] ALU_DIV  = 4'h3;
    localparam logic [3:0] ALU_SHL  = 4'h4;
    localparam logic [3:0] ALU_SHR  = 4'h5;
    localparam logic [3:0] ALU_ROL  = 4'h6;
    localparam logic [3:0] ALU_ROR  = 4'h7;
    localparam logic [3:0] ALU_AND  = 4'h8;
    localparam logic [3:0] ALU_OR   = 4'h9;
    localparam logic [3:0] ALU_XOR  = 4'hA;
    localparam logic [3:0] ALU_NOR  = 4'hB;
    localparam logic [3:0] ALU_NAND = 4'hC;
    localparam logic [3:0] ALU_XNOR = 4'hD;
    localparam logic [3:0] ALU_GT   = 4'hE;
    localparam logic [3:0] ALU_EQ   = 4'hF;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_DBZ   = 1;
    localparam int FLAG_ZERO  = 2;

    localparam int CMD_W = 24;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [3:0] tag;
    } cmd_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Bundle of command, ALU-drive, response and status signals around alu_ctrl.
// The slave side is the controller; the master side is its environment.
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  cmd_sel;
    logic [3:0]  cmd_tag;

    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result;
    logic [7:0]  alu_quotient;
    logic [7:0]  alu_remainder;
    logic        alu_carry;
    logic        alu_dbz;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [7:0]  rsp_remainder;
    logic [3:0]  rsp_tag;
    logic [2:0]  rsp_flags;

    logic [7:0]  dbz_count;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  alu_result, alu_quotient, alu_remainder, alu_carry, alu_dbz,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_result, rsp_remainder, rsp_tag, rsp_flags,
        output dbz_count, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output alu_result, alu_quotient, alu_remainder, alu_carry, alu_dbz,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_result, rsp_remainder, rsp_tag, rsp_flags,
        input  dbz_count, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Power-of-two command FIFO; full/empty come from the registered occupancy
// so a pop in the same cycle never frees a slot early.
module alu_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: queues ALU commands, drives an external combinational ALU and
// returns each result with its tag through a valid/ready response port.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_ctrl_if.slave bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    cmd_t        w_cmd;
    cmd_t        w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_capture;
    logic        w_done;
    logic [2:0]  w_flags;

    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [3:0]  r_alu_sel;
    logic [3:0]  r_tag;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_result;
    logic [7:0]  r_rsp_rem;
    logic [2:0]  r_rsp_flags;
    logic [3:0]  r_rsp_tag;
    logic [7:0]  r_dbz_count;

    // The quotient duplicates alu_result[7:0] for divides and is not needed.
    logic        w_unused_quotient;
    assign w_unused_quotient = ^bus.alu_quotient;

    assign w_cmd  = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel, tag: bus.cmd_tag};
    assign w_push = bus.cmd_valid & ~w_full;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_done = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Carry is only meaningful for add; other opcodes may leave junk on it.
    always_comb begin
        w_flags             = '0;
        w_flags[FLAG_CARRY] = bus.alu_carry & (r_alu_sel == ALU_ADD);
        w_flags[FLAG_DBZ]   = bus.alu_dbz;
        w_flags[FLAG_ZERO]  = (bus.alu_result == 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_tag     <= '0;
        end else if (w_pop) begin
            r_alu_a   <= w_head.a;
            r_alu_b   <= w_head.b;
            r_alu_sel <= w_head.sel;
            r_tag     <= w_head.tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_rem    <= '0;
            r_rsp_flags  <= '0;
            r_rsp_tag    <= '0;
        end else if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= bus.alu_result;
            r_rsp_rem    <= bus.alu_remainder;
            r_rsp_flags  <= w_flags;
            r_rsp_tag    <= r_tag;
        end else if (w_done) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dbz_count <= '0;
        else if (w_done && r_rsp_flags[FLAG_DBZ] && (r_dbz_count != 8'hFF))
            r_dbz_count <= r_dbz_count + 8'd1;
    end

    assign bus.cmd_ready     = ~w_full;
    assign bus.alu_a         = r_alu_a;
    assign bus.alu_b         = r_alu_b;
    assign bus.alu_sel       = r_alu_sel;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_remainder = r_rsp_rem;
    assign bus.rsp_flags     = r_rsp_flags;
    assign bus.rsp_tag       = r_rsp_tag;
    assign bus.dbz_count     = r_dbz_count;
    assign bus.busy          = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a behavioural ALU stands in for the external datapath
// and a queue of predicted responses checks order, tags, flags and counters.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  rem;
        logic        carry;
        logic        dbz;
    } alu_out_t;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  rem;
        logic [2:0]  flags;
        logic [3:0]  tag;
    } rsp_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    int       vecs = 0;
    int       errs = 0;
    int       dbz_model = 0;
    rsp_t     expq[$];
    alu_out_t w_alu;

    alu_ctrl_if bus();

    alu_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External ALU behaviour; carry deliberately carries junk on non-add ops.
    function automatic alu_out_t alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] sel);
        alu_out_t o;
        o.res = '0; o.rem = '0; o.carry = a[7]; o.dbz = 1'b0;
        case (sel)
            ALU_ADD:  begin o.res = {8'h0, a} + {8'h0, b}; o.carry = o.res[8]; end
            ALU_SUB:  begin o.res = {8'h0, a} - {8'h0, b}; o.carry = (a < b); end
            ALU_MUL:  o.res = {8'h0, a} * {8'h0, b};
            ALU_DIV:  if (b == 8'd0) begin o.res = 16'hDEAD; o.dbz = 1'b1; end
                      else begin o.res = {8'h0, a / b}; o.rem = a % b; end
            ALU_SHL:  o.res = {7'h0, a, 1'b0};
            ALU_SHR:  o.res = {9'h0, a[7:1]};
            ALU_ROL:  o.res = {8'h0, a[6:0], a[7]};
            ALU_ROR:  o.res = {8'h0, a[0], a[7:1]};
            ALU_AND:  o.res = {8'h0, a & b};
            ALU_OR:   o.res = {8'h0, a | b};
            ALU_XOR:  o.res = {8'h0, a ^ b};
            ALU_NOR:  o.res = {8'h0, ~(a | b)};
            ALU_NAND: o.res = {8'h0, ~(a & b)};
            ALU_XNOR: o.res = {8'h0, ~(a ^ b)};
            ALU_GT:   o.res = {15'h0, a > b};
            default:  o.res = {15'h0, a == b};
        endcase
        return o;
    endfunction

    assign w_alu             = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_result    = w_alu.res;
    assign bus.alu_quotient  = w_alu.res[7:0];
    assign bus.alu_remainder = w_alu.rem;
    assign bus.alu_carry     = w_alu.carry;
    assign bus.alu_dbz       = w_alu.dbz;

    function automatic rsp_t ref_rsp(cmd_t c);
        alu_out_t o;
        rsp_t r;
        o = alu_fn(c.a, c.b, c.sel);
        r.res = o.res;
        r.rem = o.rem;
        r.tag = c.tag;
        r.flags = '0;
        r.flags[FLAG_CARRY] = (c.sel == ALU_ADD) && ((int'(c.a) + int'(c.b)) > 255);
        r.flags[FLAG_DBZ]   = (c.sel == ALU_DIV) && (c.b == 8'd0);
        r.flags[FLAG_ZERO]  = (o.res == 16'd0);
        return r;
    endfunction

    function automatic rsp_t obs();
        return {bus.rsp_result, bus.rsp_remainder, bus.rsp_flags, bus.rsp_tag};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c = cmd_t'(24'($urandom));
        if ($urandom_range(0, 3) == 0) c.b = 8'd0;
        return c;
    endfunction

    task automatic drive(cmd_t c);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = c.a; bus.cmd_b = c.b; bus.cmd_sel = c.sel; bus.cmd_tag = c.tag;
    endtask

    // Drive one command for one edge; caller guarantees cmd_ready.
    task automatic send(cmd_t c);
        drive(c);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_sel = 0; bus.cmd_tag = 0;
        bus.rsp_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", bus.rsp_valid); end
        vecs++;
        if (obs() !== rsp_t'(0)) begin errs++; $display("FAIL rst_rsp got %h want 0", obs()); end
        vecs++;
        if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 20'h0) begin errs++; $display("FAIL rst_alu got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        vecs++;
        if ({bus.dbz_count, bus.busy} !== 9'h0) begin errs++; $display("FAIL rst_dbz_busy got %h want 0", {bus.dbz_count, bus.busy}); end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_add();
        cmd_t c;
        rsp_t e, first;
        c = '{a: 8'd200, b: 8'd100, sel: ALU_ADD, tag: 4'd3};
        bus.rsp_ready = 1'b0;
        send(c);
        vecs++;
        if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL add_lat_n got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        vecs++;
        if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel} !== {1'b0, 8'd200, 8'd100, ALU_ADD})
            begin errs++; $display("FAIL add_issue got %h want %h", {bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel}, {1'b0, 8'd200, 8'd100, ALU_ADD}); end
        @(negedge clk);
        vecs++;
        if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL add_lat_n2 got %b want 1", bus.rsp_valid); end
        e = '{res: 16'h012C, rem: 8'h00, flags: 3'b001, tag: 4'd3};
        vecs++;
        if (obs() !== e) begin errs++; $display("FAIL add_rsp got %h want %h", obs(), e); end
        first = obs();
        repeat (2) @(negedge clk);
        vecs++;
        if ({bus.rsp_valid, obs()} !== {1'b1, first}) begin errs++; $display("FAIL add_hold got %h want %h", {bus.rsp_valid, obs()}, {1'b1, first}); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin errs++; $display("FAIL add_done got %b want 00", {bus.rsp_valid, bus.busy}); end
    endtask

    task automatic test_div();
        cmd_t c;
        rsp_t e;
        bit ok;
        bus.rsp_ready = 1'b1;
        c = '{a: 8'd100, b: 8'd7, sel: ALU_DIV, tag: 4'd5};
        send(c);
        wait_valid(ok);
        e = '{res: 16'h000E, rem: 8'd2, flags: 3'b000, tag: 4'd5};
        vecs++;
        if (!ok || obs() !== e) begin errs++; $display("FAIL div_rsp got %h want %h", obs(), e); end
        @(negedge clk);
        c = '{a: 8'd100, b: 8'd0, sel: ALU_DIV, tag: 4'd6};
        send(c);
        wait_valid(ok);
        vecs++;
        if (!ok || {bus.rsp_result, bus.rsp_flags[FLAG_DBZ], bus.rsp_tag} !== {16'hDEAD, 1'b1, 4'd6})
            begin errs++; $display("FAIL div_dbz got %h want %h", {bus.rsp_result, bus.rsp_flags[FLAG_DBZ], bus.rsp_tag}, {16'hDEAD, 1'b1, 4'd6}); end
        @(negedge clk);
        dbz_model++;
        vecs++;
        if (bus.dbz_count !== 8'(dbz_model)) begin errs++; $display("FAIL div_count got %0d want %0d", bus.dbz_count, dbz_model); end
    endtask

    task automatic test_compare();
        cmd_t c;
        bit ok;
        bus.rsp_ready = 1'b1;
        c = '{a: 8'd5, b: 8'd5, sel: ALU_XOR, tag: 4'd1};
        send(c);
        wait_valid(ok);
        vecs++;
        if (!ok || {bus.rsp_result, bus.rsp_flags} !== {16'd0, 3'b100})
            begin errs++; $display("FAIL cmp_xor got %h want %h", {bus.rsp_result, bus.rsp_flags}, {16'd0, 3'b100}); end
        @(negedge clk);
        c = '{a: 8'd5, b: 8'd5, sel: ALU_EQ, tag: 4'd2};
        send(c);
        wait_valid(ok);
        vecs++;
        if (!ok || {bus.rsp_result, bus.rsp_flags} !== {16'd1, 3'b000})
            begin errs++; $display("FAIL cmp_eq got %h want %h", {bus.rsp_result, bus.rsp_flags}, {16'd1, 3'b000}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        cmd_t c;
        rsp_t e;
        int got, last;
        bit pend;
        bus.rsp_ready = 1'b0;
        expq.delete();
        c = '0;
        for (int t = 0; t < 6; t++) begin
            c = rand_cmd();
            c.tag = 4'(t);
            drive(c);
            vecs++;
            if (bus.cmd_ready !== (t < 5)) begin errs++; $display("FAIL bp_ready tag %0d got %b want %b", t, bus.cmd_ready, (t < 5)); end
            if (bus.cmd_ready) expq.push_back(ref_rsp(c));
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({bus.rsp_valid, bus.cmd_ready, obs()} !== {2'b10, expq[0]})
                begin errs++; $display("FAIL bp_stall got %h want %h", {bus.rsp_valid, bus.cmd_ready, obs()}, {2'b10, expq[0]}); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        got = 0; last = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (pend) begin bus.cmd_valid = 1'b0; pend = 1'b0; end
            if (bus.cmd_valid && bus.cmd_ready) begin expq.push_back(ref_rsp(c)); pend = 1'b1; end
            if (bus.rsp_valid) begin
                vecs++;
                if (expq.size() == 0) begin errs++; $display("FAIL bp_extra got %h want none", obs()); end
                else begin
                    e = expq.pop_front();
                    if (obs() !== e) begin errs++; $display("FAIL bp_order got %h want %h", obs(), e); end
                    if (e.flags[FLAG_DBZ] && dbz_model < 255) dbz_model++;
                end
                if (got > 0) begin
                    vecs++;
                    if (cyc - last != 2) begin errs++; $display("FAIL bp_rate got %0d want 2", cyc - last); end
                end
                last = cyc;
                got++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        vecs++;
        if (got != 6) begin errs++; $display("FAIL bp_count got %0d want 6", got); end
    endtask

    task automatic test_random();
        cmd_t c;
        rsp_t e, prev;
        int sent, got;
        bit pend, stalled;
        sent = 0; got = 0; pend = 1'b0; stalled = 1'b0; prev = '0; c = '0;
        expq.delete();
        bus.cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
            if (pend) begin bus.cmd_valid = 1'b0; pend = 1'b0; end
            if (!bus.cmd_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
                c = rand_cmd();
                drive(c);
                sent++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin expq.push_back(ref_rsp(c)); pend = 1'b1; end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            vecs++;
            if (bus.dbz_count !== 8'(dbz_model)) begin errs++; $display("FAIL rnd_dbz got %0d want %0d", bus.dbz_count, dbz_model); end
            if (stalled) begin
                vecs++;
                if ({bus.rsp_valid, obs()} !== {1'b1, prev}) begin errs++; $display("FAIL rnd_hold got %h want %h", {bus.rsp_valid, obs()}, {1'b1, prev}); end
            end
            stalled = 1'b0;
            if (bus.rsp_valid) begin
                prev = obs();
                if (bus.rsp_ready) begin
                    vecs++;
                    if (expq.size() == 0) begin errs++; $display("FAIL rnd_extra got %h want none", obs()); end
                    else begin
                        e = expq.pop_front();
                        if (obs() !== e) begin errs++; $display("FAIL rnd_rsp got %h want %h", obs(), e); end
                        if (e.flags[FLAG_DBZ] && dbz_model < 255) dbz_model++;
                    end
                    got++;
                end else stalled = 1'b1;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({got, bus.busy, bus.dbz_count} !== {32'd40, 1'b0, 8'(dbz_model)})
            begin errs++; $display("FAIL rnd_end got %0d/%b/%0d want 40/0/%0d", got, bus.busy, bus.dbz_count, dbz_model); end
    endtask

    task automatic test_reset_midflight();
        cmd_t c;
        bit ok;
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            c = rand_cmd();
            c.tag = 4'(t + 8);
            drive(c);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        wait_valid(ok);
        vecs++;
        if (!ok || bus.busy !== 1'b1) begin errs++; $display("FAIL mid_setup got %b/%b want 1/1", ok, bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({bus.rsp_valid, obs()} !== '0) begin errs++; $display("FAIL mid_rsp got %h want 0", {bus.rsp_valid, obs()}); end
        vecs++;
        if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.dbz_count, bus.busy} !== '0)
            begin errs++; $display("FAIL mid_state got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_sel, bus.dbz_count, bus.busy}); end
        expq.delete();
        dbz_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vecs++;
            if ({bus.rsp_valid, bus.busy, bus.cmd_ready} !== 3'b001)
                begin errs++; $display("FAIL mid_stale got %b want 001", {bus.rsp_valid, bus.busy, bus.cmd_ready}); end
        end
    endtask

    task automatic test_saturation();
        cmd_t c;
        int sent, got;
        bit pend;
        sent = 0; got = 0; pend = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 260; cyc++) begin
            if (pend) begin bus.cmd_valid = 1'b0; pend = 1'b0; end
            if (!bus.cmd_valid && sent < 260) begin
                c = '{a: 8'($urandom), b: 8'd0, sel: ALU_DIV, tag: 4'(sent)};
                drive(c);
                sent++;
            end
            if (bus.cmd_valid && bus.cmd_ready) pend = 1'b1;
            if (bus.rsp_valid) begin
                got++;
                if (got == 255) begin
                    vecs++;
                    if (bus.dbz_count !== 8'd254) begin errs++; $display("FAIL sat_pre got %0d want 254", bus.dbz_count); end
                end
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({got, bus.dbz_count} !== {32'd260, 8'd255}) begin errs++; $display("FAIL sat_final got %0d/%0d want 260/255", got, bus.dbz_count); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_compare();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
